// File: rtl/col_packet_decoder_3b.sv
// Column packet decoder: rebuilds 3-bit pixel and 32-bit timestamp items
// from the encoder's 16-bit word stream, buffered in a 2-write-port FIFO.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   encoded_dat[15:0] packet word, qualified by data_ready
//   out_valid/ready   item handshake toward the sink
//   out_kind[1:0]     0=pixel, 1=resurrection TS, 2=epoch TS
//   pix_out[2:0]      pixel value (kind 0)
//   ts_out[31:0]      timestamp (kind 1/2)
//   overflow          sticky, a FIFO entry was dropped
//   fmt_err           1-cycle pulse on a truncated resurrection packet
// Optional (macro COL_DEC_STATS_EN):
//   raw_pkt_cnt[15:0] saturating count of RAW words
//   err_cnt[7:0]      saturating count of fmt errors + dropped entries
module col_packet_decoder_3b #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] encoded_dat,
  input  logic        data_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_kind,
  output logic [2:0]  pix_out,
  output logic [31:0] ts_out,
  output logic        overflow,
  output logic        fmt_err
`ifdef COL_DEC_STATS_EN
  ,
  output logic [15:0] raw_pkt_cnt,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [15:0] RESURRECT = 16'h8000;
  localparam int CW = FIFO_AW + 1;

  typedef enum logic [1:0] {
    D_RAW,
    D_PEND,
    D_TS_HI,
    D_TS_LO
  } st_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  cnt;
    logic [31:0] data;
  } ent_t;

  // Pixel count of a flush word: a 0 marker with only 1s above it.
  function automatic logic [2:0] flush_cnt(input logic [14:0] p);
    if (!p[0] && (&p[14:1]))       return 3'd0;
    else if (!p[3] && (&p[14:4]))  return 3'd1;
    else if (!p[6] && (&p[14:7]))  return 3'd2;
    else if (!p[9] && (&p[14:10])) return 3'd3;
    else if (!p[12] && (&p[14:13])) return 3'd4;
    else                           return 3'd5;
  endfunction

  function automatic ent_t pix_ent(input logic [14:0] p,
                                   input logic [2:0] n);
    ent_t e;
    e.kind = 2'd0;
    e.cnt  = n;
    e.data = {17'd0, p};
    return e;
  endfunction

  function automatic ent_t ts_ent(input logic [1:0] k,
                                  input logic [31:0] t);
    ent_t e;
    e.kind = k;
    e.cnt  = 3'd1;
    e.data = t;
    return e;
  endfunction

  function automatic ent_t epoch_ent(input logic [15:0] w);
    return ts_ent(2'd2, {1'b0, w[14:0], 16'h0000});
  endfunction

  // Input register stage
  logic [15:0] din_q;
  logic        dv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= '0;
      dv_q  <= 1'b0;
    end else begin
      din_q <= encoded_dat;
      dv_q  <= data_ready;
    end
  end

  // Decode FSM
  st_t         state_q, state_d;
  logic [15:0] lat_q, lat_d;
  logic        a_v, b_v, err, raw_seen;
  ent_t        a, b;
  logic [2:0]  fk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= D_RAW;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    a_v      = 1'b0;
    a        = '0;
    b_v      = 1'b0;
    b        = '0;
    err      = 1'b0;
    raw_seen = 1'b0;
    fk       = flush_cnt(lat_q[14:0]);
    unique case (state_q)
      D_RAW: begin
        if (dv_q) begin
          if (!din_q[15]) begin
            a_v      = 1'b1;
            a        = pix_ent(din_q[14:0], 3'd5);
            raw_seen = 1'b1;
          end else if (din_q == RESURRECT) begin
            state_d = D_TS_HI;
          end else begin
            lat_d   = din_q;
            state_d = D_PEND;
          end
        end
      end
      D_PEND: begin
        state_d = D_RAW;
        // A second marker word proves the latched one was a flush.
        if (dv_q && din_q[15] && din_q != RESURRECT) begin
          a_v = (fk != 3'd0);
          a   = pix_ent(lat_q[14:0], fk);
          b_v = 1'b1;
          b   = epoch_ent(din_q);
        end else begin
          a_v = 1'b1;
          a   = epoch_ent(lat_q);
          if (dv_q) begin
            if (!din_q[15]) begin
              b_v      = 1'b1;
              b        = pix_ent(din_q[14:0], 3'd5);
              raw_seen = 1'b1;
            end else if (din_q == RESURRECT) begin
              state_d = D_TS_HI;
            end else begin
              lat_d   = din_q;
              state_d = D_PEND;
            end
          end
        end
      end
      D_TS_HI: begin
        if (dv_q) begin
          lat_d   = din_q;
          state_d = D_TS_LO;
        end else begin
          err     = 1'b1;
          state_d = D_RAW;
        end
      end
      D_TS_LO: begin
        state_d = D_RAW;
        if (dv_q) begin
          a_v = 1'b1;
          a   = ts_ent(2'd1, {lat_q, din_q});
        end else begin
          err = 1'b1;
        end
      end
      default: state_d = D_RAW;
    endcase
  end

  // Compact the two push candidates onto write ports 0/1.
  logic w0_v, w1_v;
  ent_t w0, w1;

  always_comb begin
    w0_v = a_v | b_v;
    w0   = a_v ? a : b;
    w1_v = a_v & b_v;
    w1   = b;
  end

  // Item FIFO
  ent_t             mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       beat_q;
  ent_t             head;
  logic             last_beat, pop, acc0, acc1;
  logic             drop0, drop1;
  logic [CW:0]      space;
  logic [1:0]       n_push;
  logic [2:0]       sel;
  logic [2:0]       px;

  assign head      = mem_q[rp_q];
  assign out_valid = (cnt_q != '0);
  assign last_beat = (head.kind != 2'd0) ||
                     (beat_q == head.cnt - 3'd1);
  assign pop       = out_valid & out_ready & last_beat;

  // A pop this cycle frees a slot for this cycle's pushes.
  assign space  = (CW+1)'(FIFO_DEPTH) - (CW+1)'(cnt_q) +
                  (CW+1)'(pop);
  assign acc0   = w0_v && (space != '0);
  assign acc1   = w1_v && (space >= (CW+1)'(2));
  assign drop0  = w0_v & ~acc0;
  assign drop1  = w1_v & ~acc1;
  assign n_push = {1'b0, acc0} + {1'b0, acc1};

  always_ff @(posedge clk) begin
    if (acc0) mem_q[wp_q] <= w0;
    if (acc1) mem_q[wp_q + FIFO_AW'(1)] <= w1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      beat_q <= '0;
    end else begin
      wp_q  <= wp_q + FIFO_AW'(n_push);
      cnt_q <= cnt_q + CW'(n_push) - CW'(pop);
      if (pop) rp_q <= rp_q + FIFO_AW'(1);
      if (out_valid && out_ready) begin
        beat_q <= last_beat ? 3'd0 : beat_q + 3'd1;
      end
    end
  end

  // Oldest pixel sits highest in the payload.
  assign sel = head.cnt - 3'd1 - beat_q;

  always_comb begin
    px = '0;
    case (sel)
      3'd0:    px = head.data[2:0];
      3'd1:    px = head.data[5:3];
      3'd2:    px = head.data[8:6];
      3'd3:    px = head.data[11:9];
      default: px = head.data[14:12];
    endcase
  end

  assign out_kind = out_valid ? head.kind : 2'd0;
  assign pix_out  = (out_valid && head.kind == 2'd0) ? px : 3'd0;
  assign ts_out   = (out_valid && head.kind != 2'd0) ?
                    head.data : 32'd0;

  logic ovf_q, ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_q | drop0 | drop1;
      ferr_q <= err;
    end
  end

  assign overflow = ovf_q;
  assign fmt_err  = ferr_q;

`ifdef COL_DEC_STATS_EN
  logic [15:0] raw_q;
  logic [7:0]  errc_q;
  logic [1:0]  einc;

  assign einc = {1'b0, err} + {1'b0, drop0} + {1'b0, drop1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q  <= '0;
      errc_q <= '0;
    end else begin
      if (raw_seen && raw_q != 16'hFFFF) raw_q <= raw_q + 16'd1;
      if (errc_q > 8'hFF - 8'(einc)) errc_q <= 8'hFF;
      else                           errc_q <= errc_q + 8'(einc);
    end
  end

  assign raw_pkt_cnt = raw_q;
  assign err_cnt     = errc_q;
`else
  logic unused_stats;
  assign unused_stats = raw_seen;
`endif

endmodule

// File: tb/tb_col_packet_decoder_3b.sv
// Scoreboard bench for col_packet_decoder_3b: directed word sequences,
// expected items queued at stimulus time, popped by a negedge monitor.
module tb_col_packet_decoder_3b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] encoded_dat;
  logic        data_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_kind;
  logic [2:0]  pix_out;
  logic [31:0] ts_out;
  logic        overflow;
  logic        fmt_err;
`ifdef COL_DEC_STATS_EN
  logic [15:0] raw_pkt_cnt;
  logic [7:0]  err_cnt;
`endif

  col_packet_decoder_3b dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .encoded_dat (encoded_dat),
    .data_ready  (data_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_kind    (out_kind),
    .pix_out     (pix_out),
    .ts_out      (ts_out),
    .overflow    (overflow),
`ifdef COL_DEC_STATS_EN
    .raw_pkt_cnt (raw_pkt_cnt),
    .err_cnt     (err_cnt),
`endif
    .fmt_err     (fmt_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  pix;
    logic [31:0] ts;
  } item_t;

  item_t expq[$];
  item_t e;
  int    checks   = 0;
  int    failures = 0;
  int    fmt_cnt  = 0;
  int    rmode    = 0;
  logic        stall_prev = 1'b0;
  logic [37:0] out_prev;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic exp_pix(input logic [2:0] p);
    expq.push_back({2'd0, p, 32'd0});
  endtask

  task automatic exp_ts(input logic [1:0] k, input logic [31:0] t);
    expq.push_back({k, 3'd0, t});
  endtask

  task automatic exp_raw(input logic [15:0] w);
    for (int i = 4; i >= 0; i--) begin
      logic [14:0] v;
      v = w[14:0];
      exp_pix(v[3*i +: 3]);
    end
  endtask

  task automatic send(input logic [15:0] w);
    encoded_dat = w;
    data_ready  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    data_ready  = 1'b0;
    encoded_dat = 16'h0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int left;
    data_ready = 1'b0;
    left = 400;
    while (left > 0 && (expq.size() != 0 || out_valid)) begin
      @(posedge clk);
      #1;
      left--;
    end
    chk(name, {31'd0, out_valid, 32'(expq.size())}, 64'd0);
  endtask

  // Sink readiness driver
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (fmt_err) fmt_cnt++;
      if (stall_prev) begin
        chk("hold", {26'd0, out_valid, out_kind, pix_out, ts_out},
            {26'd0, out_prev});
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat kind=%0d pix=%0d ts=%h",
                   out_kind, pix_out, ts_out);
        end else begin
          e = expq.pop_front();
          if (out_kind !== e.kind ||
              (e.kind == 2'd0 && pix_out !== e.pix) ||
              (e.kind != 2'd0 && ts_out !== e.ts)) begin
            failures++;
            $display("FAIL beat actual k=%0d p=%0d t=%h required k=%0d p=%0d t=%h",
                     out_kind, pix_out, ts_out, e.kind, e.pix, e.ts);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      out_prev   = {out_valid, out_kind, pix_out, ts_out};
    end
  end

  initial begin
    rst_n       = 1'b0;
    encoded_dat = 16'h0;
    data_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_kind",  64'(out_kind),  64'd0);
    chk("rst_pix",   64'(pix_out),   64'd0);
    chk("rst_ts",    64'(ts_out),    64'd0);
    chk("rst_ovf",   64'(overflow),  64'd0);
    chk("rst_ferr",  64'(fmt_err),   64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // RAW pixels 0,2,4,5,3 and 2-cycle latency
    exp_pix(3'd0); exp_pix(3'd2); exp_pix(3'd4);
    exp_pix(3'd5); exp_pix(3'd3);
    send(16'h052B);
    data_ready = 1'b0;
    @(negedge clk);
    chk("lat_1cyc", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_2cyc", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    drain("drain_raw");

    // Resurrection timestamp
    exp_ts(2'd1, 32'h12345678);
    send(16'h8000); send(16'h1234); send(16'h5678);
    drain("drain_resurrect");

    // Flush k=1 followed by epoch
    exp_pix(3'd5);
    exp_ts(2'd2, 32'h00030000);
    send(16'hFFF5); send(16'h8003);
    drain("drain_flush1");

    // Lone epoch then idle
    exp_ts(2'd2, 32'h00070000);
    send(16'h8007);
    drain("drain_epoch");

    // Truncated resurrection, then recovery on RAW
    chk("ferr_before", 64'(fmt_cnt), 64'd0);
    send(16'h8000); send(16'h1234);
    idle(3);
    chk("ferr_pulse", 64'(fmt_cnt), 64'd1);
    exp_pix(3'd1); exp_pix(3'd1); exp_pix(3'd0);
    exp_pix(3'd6); exp_pix(3'd4);
    send(16'h1234);
    drain("drain_recover");

    // Epoch followed by RAW in the same cycle
    exp_ts(2'd2, 32'h00050000);
    exp_pix(3'd0); exp_pix(3'd2); exp_pix(3'd4);
    exp_pix(3'd5); exp_pix(3'd3);
    send(16'h8005); send(16'h052B);
    drain("drain_epoch_raw");

    // Flush k=2 then epoch
    exp_pix(3'd3); exp_pix(3'd6);
    exp_ts(2'd2, 32'h00090000);
    send(16'hFF9E); send(16'h8009);
    drain("drain_flush2");

    // Marker followed by 8000: epoch, then resurrection
    exp_ts(2'd2, 32'h7FF50000);
    exp_ts(2'd1, 32'hAAAABBBB);
    send(16'hFFF5); send(16'h8000); send(16'hAAAA); send(16'hBBBB);
    drain("drain_pend_res");

    // Flush k=0: no pixels, only the epoch
    exp_ts(2'd2, 32'h00020000);
    send(16'hFFFE); send(16'h8002);
    drain("drain_flush0");

    // Random sink backpressure
    rmode = 2;
    exp_pix(3'd0); exp_pix(3'd2); exp_pix(3'd4);
    exp_pix(3'd5); exp_pix(3'd3);
    exp_pix(3'd1); exp_pix(3'd1); exp_pix(3'd0);
    exp_pix(3'd6); exp_pix(3'd4);
    exp_ts(2'd2, 32'h00040000);
    exp_ts(2'd1, 32'hDEADBEEF);
    exp_pix(3'd0); exp_pix(3'd7); exp_pix(3'd7);
    exp_pix(3'd7); exp_pix(3'd7);
    send(16'h052B); send(16'h1234); send(16'h8004); send(16'h8000);
    send(16'hDEAD); send(16'hBEEF); send(16'h0FFF);
    drain("drain_random");
    rmode = 0;
    idle(2);

    // Overflow: 10 RAW words into an 8-deep FIFO with no sink
    chk("ovf_before", 64'(overflow), 64'd0);
    rmode = 1;
    idle(3);
    begin
      logic [15:0] words [10];
      words = '{16'h052B, 16'h1234, 16'h0FFF, 16'h0001, 16'h0002,
                16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
      for (int i = 0; i < 8; i++) exp_raw(words[i]);
      for (int i = 0; i < 10; i++) send(words[i]);
    end
    idle(4);
    chk("ovf_set", 64'(overflow), 64'd1);
    rmode = 0;
    drain("drain_overflow");
    chk("ovf_sticky", 64'(overflow), 64'd1);
    chk("ferr_total", 64'(fmt_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
